// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem addressing, IF/ID register (optional FETCH_PERF_COUNTERS_EN)
module fetch_stage #(
  parameter int N         = 24,
  parameter int MEM_DEPTH = 1025
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] if_id_instr,
  output logic [N-1:0] if_id_pc,
  output logic         if_id_valid,
  output logic         fetch_fault
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  stall_count
`endif
);

  // One extra bit so a MEM_DEPTH of exactly 2**N still compares correctly.
  localparam logic [N:0]   depth_w = (N+1)'(MEM_DEPTH);
  localparam logic [N-1:0] last_pc = N'(MEM_DEPTH - 1);

  logic [N-1:0] pc;
  logic [N-1:0] pc_next;
  logic         target_oor;
  logic         load_if_id;
  logic         clear_if_id;

  assign imem_addr = pc;

  // Redirect/advance decision; branch outranks stall, flush only touches IF/ID.
  always_comb begin
    pc_next     = pc;
    target_oor  = ({1'b0, branch_target} >= depth_w);
    clear_if_id = branch_taken | flush;
    load_if_id  = !branch_taken && !stall && !flush;
    if (branch_taken) begin
      pc_next = target_oor ? '0 : branch_target;
    end else if (!stall) begin
      pc_next = (pc == last_pc) ? '0 : pc + 1'b1;
    end
  end

  // PC, IF/ID pipeline register and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      pc <= pc_next;
      if (clear_if_id) begin
        if_id_instr <= '0;
        if_id_pc    <= '0;
        if_id_valid <= 1'b0;
      end else if (load_if_id) begin
        if_id_instr <= imem_instr;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
      end
      if (branch_taken && target_oor) begin
        fetch_fault <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Saturating counters of delivered instructions and stalled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load_if_id && fetch_count != 32'hffff_ffff) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (stall && !branch_taken && stall_count != 32'hffff_ffff) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam int N         = 24;
  localparam int MEM_DEPTH = 1025;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         branch_taken = 1'b0;
  logic [N-1:0] branch_target = '0;
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_instr;
  logic [N-1:0] if_id_instr;
  logic [N-1:0] if_id_pc;
  logic         if_id_valid;
  logic         fetch_fault;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]  fetch_count;
  logic [31:0]  stall_count;
`endif

  logic [N-1:0] mem [MEM_DEPTH];

  int           m_pc;
  logic [N-1:0] m_instr;
  logic [N-1:0] m_ipc;
  logic         m_valid;
  logic         m_fault;
  int unsigned  m_fc;
  int unsigned  m_sc;

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage #(.N(N), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .fetch_fault   (fetch_fault)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  assign imem_instr = (int'(imem_addr) < MEM_DEPTH) ? mem[int'(imem_addr)] : '0;

  task automatic model_reset();
    m_pc = 0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_fault = 1'b0; m_fc = 0; m_sc = 0;
  endtask

  // Reference behaviour for one clock edge given the current inputs.
  task automatic model_edge();
    if (branch_taken) begin
      m_instr = '0; m_ipc = '0; m_valid = 1'b0;
      if (int'(branch_target) >= MEM_DEPTH) begin
        m_pc = 0;
        m_fault = 1'b1;
      end else begin
        m_pc = int'(branch_target);
      end
    end else begin
      if (flush) begin
        m_instr = '0; m_ipc = '0; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = mem[m_pc]; m_ipc = N'(m_pc); m_valid = 1'b1;
        m_fc++;
      end
      if (stall) m_sc++;
      else m_pc = (m_pc + 1) % MEM_DEPTH;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_total++; if (imem_addr !== '0) $display("FAIL reset_pc got %h want 0", imem_addr); else n_pass++;
    n_total++; if (if_id_instr !== '0) $display("FAIL reset_instr got %h want 0", if_id_instr); else n_pass++;
    n_total++; if (if_id_pc !== '0) $display("FAIL reset_if_id_pc got %h want 0", if_id_pc); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fetch_fault); else n_pass++;
  endtask

  task automatic test_free_run();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++; if (if_id_pc !== N'(i)) $display("FAIL free_pc[%0d] got %h want %h", i, if_id_pc, N'(i)); else n_pass++;
      n_total++; if (if_id_instr !== N'(i + 'h100)) $display("FAIL free_instr[%0d] got %h want %h", i, if_id_instr, N'(i + 'h100)); else n_pass++;
      n_total++; if (if_id_valid !== 1'b1) $display("FAIL free_valid[%0d] got %b want 1", i, if_id_valid); else n_pass++;
      n_total++; if (imem_addr !== N'(i + 1)) $display("FAIL free_addr[%0d] got %h want %h", i, imem_addr, N'(i + 1)); else n_pass++;
    end
  endtask

  task automatic test_stall();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (imem_addr !== N'(5)) $display("FAIL stall_pc[%0d] got %h want 5", k, imem_addr); else n_pass++;
      n_total++; if (if_id_pc !== N'(4)) $display("FAIL stall_if_id_pc[%0d] got %h want 4", k, if_id_pc); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++; if (if_id_pc !== N'(5)) $display("FAIL stall_release_pc got %h want 5", if_id_pc); else n_pass++;
    n_total++; if (if_id_instr !== N'('h105)) $display("FAIL stall_release_instr got %h want 105", if_id_instr); else n_pass++;
  endtask

  task automatic test_branch_stall();
    branch_taken = 1'b1; branch_target = N'('h20); stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL branch_bubble got %b want 0", if_id_valid); else n_pass++;
    n_total++; if (imem_addr !== N'('h20)) $display("FAIL branch_pc got %h want 20", imem_addr); else n_pass++;
    tick();
    n_total++; if (if_id_pc !== N'('h20)) $display("FAIL branch_if_id_pc got %h want 20", if_id_pc); else n_pass++;
    n_total++; if (if_id_instr !== N'('h120)) $display("FAIL branch_instr got %h want 120", if_id_instr); else n_pass++;
    n_total++; if (if_id_valid !== 1'b1) $display("FAIL branch_valid got %b want 1", if_id_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = N'(1024);
    tick();
    branch_taken = 1'b0;
    tick();
    n_total++; if (if_id_pc !== N'(1024)) $display("FAIL wrap_last got %h want 400", if_id_pc); else n_pass++;
    n_total++; if (imem_addr !== '0) $display("FAIL wrap_pc got %h want 0", imem_addr); else n_pass++;
    tick();
    n_total++; if (if_id_pc !== '0) $display("FAIL wrap_first got %h want 0", if_id_pc); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL wrap_fault got %b want 0", fetch_fault); else n_pass++;
  endtask

  task automatic test_fault();
    branch_taken = 1'b1; branch_target = N'('h500);
    tick();
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL fault_set got %b want 1", fetch_fault); else n_pass++;
    n_total++; if (imem_addr !== '0) $display("FAIL fault_pc got %h want 0", imem_addr); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL fault_valid got %b want 0", if_id_valid); else n_pass++;
    branch_target = N'(3);
    tick();
    branch_taken = 1'b0;
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL fault_sticky got %b want 1", fetch_fault); else n_pass++;
    n_total++; if (imem_addr !== N'(3)) $display("FAIL fault_rebranch got %h want 3", imem_addr); else n_pass++;
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL rand_fault_clear got %b want 0", fetch_fault); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = N'($urandom_range(0, 1100));
      tick();
      n_total++; if (imem_addr !== N'(m_pc)) $display("FAIL rand_pc[%0d] got %h want %h", i, imem_addr, N'(m_pc)); else n_pass++;
      n_total++; if (if_id_instr !== m_instr) $display("FAIL rand_instr[%0d] got %h want %h", i, if_id_instr, m_instr); else n_pass++;
      n_total++; if (if_id_pc !== m_ipc) $display("FAIL rand_if_id_pc[%0d] got %h want %h", i, if_id_pc, m_ipc); else n_pass++;
      n_total++; if (if_id_valid !== m_valid) $display("FAIL rand_valid[%0d] got %b want %b", i, if_id_valid, m_valid); else n_pass++;
      n_total++; if (fetch_fault !== m_fault) $display("FAIL rand_fault[%0d] got %b want %b", i, fetch_fault, m_fault); else n_pass++;
`ifdef FETCH_PERF_COUNTERS_EN
      n_total++; if (fetch_count !== m_fc) $display("FAIL rand_fetch_count[%0d] got %0d want %0d", i, fetch_count, m_fc); else n_pass++;
      n_total++; if (stall_count !== m_sc) $display("FAIL rand_stall_count[%0d] got %0d want %0d", i, stall_count, m_sc); else n_pass++;
`endif
    end
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_async_reset();
    branch_taken = 1'b1; branch_target = N'(6);
    tick();
    branch_taken = 1'b0;
    tick();
    n_total++; if (imem_addr !== N'(7)) $display("FAIL async_setup_pc got %h want 7", imem_addr); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_total++; if (imem_addr !== '0) $display("FAIL async_pc got %h want 0", imem_addr); else n_pass++;
    n_total++; if (if_id_instr !== '0) $display("FAIL async_instr got %h want 0", if_id_instr); else n_pass++;
    n_total++; if (if_id_pc !== '0) $display("FAIL async_if_id_pc got %h want 0", if_id_pc); else n_pass++;
    n_total++; if (if_id_valid !== 1'b0) $display("FAIL async_valid got %b want 0", if_id_valid); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL async_fault got %b want 0", fetch_fault); else n_pass++;
`ifdef FETCH_PERF_COUNTERS_EN
    n_total++; if (fetch_count !== 32'd0) $display("FAIL async_fetch_count got %0d want 0", fetch_count); else n_pass++;
    n_total++; if (stall_count !== 32'd0) $display("FAIL async_stall_count got %0d want 0", stall_count); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++; if (if_id_pc !== '0) $display("FAIL async_restart_pc got %h want 0", if_id_pc); else n_pass++;
    n_total++; if (if_id_instr !== N'('h100)) $display("FAIL async_restart_instr got %h want 100", if_id_instr); else n_pass++;
    n_total++; if (if_id_valid !== 1'b1) $display("FAIL async_restart_valid got %b want 1", if_id_valid); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = N'(i + 'h100);
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_fault();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
